// File: rtl/core_ifu_prefetch.sv
// Instruction-fetch unit: pipelined req/gnt/rvalid fetches buffered in a prefetch FIFO
// and presented to ID with a valid/ready handshake; EX jumps flush and drop stale responses.
module core_ifu_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              bus_hold_flag_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [31:0]       ibus_rdata_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_addr;
  logic [CNT_W-1:0]  count;
  logic [OUT_W-1:0]  out_cnt;
  logic [OUT_W-1:0]  drop_cnt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [31:0]       data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic              issue_ok;
  logic              granted;
  logic              resp;
  logic              discard;
  logic              push;
  logic              pop;
  logic [OUT_W-1:0]  out_cnt_nxt;
  logic [ADDR_W-1:0] jump_target;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^jump_addr_i[1:0];

  // A request reserves a FIFO slot, so the FIFO can never overflow.
  always_comb begin
    issue_ok    = (32'(out_cnt) < MAX_OUT) && ((32'(count) + 32'(out_cnt)) < DEPTH);
    ibus_req_o  = rst & ~jump_flag_i & ~bus_hold_flag_i & issue_ok;
    granted     = ibus_req_o & ibus_gnt_i;
    resp        = ibus_rvalid_i & (out_cnt != '0);
    discard     = jump_flag_i | (drop_cnt != '0);
    push        = resp & ~discard;
    pop         = (count != '0) & inst_ready_i & ~jump_flag_i;
    out_cnt_nxt = out_cnt + OUT_W'(granted) - OUT_W'(resp);
    jump_target = {jump_addr_i[ADDR_W-1:2], 2'b00};
  end

  assign ibus_addr_o  = fetch_pc;
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? data_mem[rd_ptr] : NOP;
  assign inst_addr_o  = inst_valid_o ? addr_mem[rd_ptr] : '0;

  // Control state; a jump flushes the FIFO and marks every in-flight response stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      resp_addr <= RESET_PC;
      count     <= '0;
      out_cnt   <= '0;
      drop_cnt  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      out_cnt <= out_cnt_nxt;
      if (jump_flag_i) begin
        fetch_pc  <= jump_target;
        resp_addr <= jump_target;
        drop_cnt  <= out_cnt_nxt;
        count     <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
      end else begin
        if (granted) fetch_pc <= fetch_pc + ADDR_W'(4);
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - OUT_W'(1);
        if (push) begin
          wr_ptr    <= wr_ptr + PTR_W'(1);
          resp_addr <= resp_addr + ADDR_W'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= ibus_rdata_i;
      addr_mem[wr_ptr] <= resp_addr;
    end
  end

endmodule

// File: tb/tb_core_ifu_prefetch.sv
// Bench for core_ifu_prefetch: random bus timing against a queue-based fetch model.
module tb_core_ifu_prefetch;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        bus_hold_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  always #5 clk = ~clk;

  core_ifu_prefetch #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst_n),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .bus_hold_flag_i(bus_hold_flag_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i)
  );

  typedef struct { logic [31:0] addr; logic stale; } req_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] addr; int unsigned due; } bus_t;

  req_t        m_out[$];
  ent_t        m_fifo[$];
  bus_t        bus_q[$];
  logic [31:0] m_pc;
  int unsigned cyc = 1;
  int unsigned last_due = 0;
  int unsigned lat_lo = 1, lat_hi = 1, gnt_pct = 100;
  bit          stray_en = 1'b0;
  logic        s_req;
  logic [31:0] s_addr;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // One clock: drive bus, compare all outputs with the model, then advance model and bus.
  task automatic step();
    logic        from_bus, e_req, e_valid, resp;
    logic [31:0] e_inst, e_iaddr;
    int unsigned due;
    req_t        r;
    from_bus = 1'b0;
    if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
      ibus_rvalid_i = 1'b1; ibus_rdata_i = mem(bus_q[0].addr); from_bus = 1'b1;
    end else if (stray_en && m_out.size() == 0 && $urandom_range(0, 1) == 1) begin
      ibus_rvalid_i = 1'b1; ibus_rdata_i = $urandom;
    end else begin
      ibus_rvalid_i = 1'b0; ibus_rdata_i = $urandom;
    end
    ibus_gnt_i = ($urandom_range(0, 99) < gnt_pct);
    #1;
    e_req   = rst_n && !jump_flag_i && !bus_hold_flag_i && (m_out.size() < int'(MAX_OUT))
              && (m_fifo.size() + m_out.size() < int'(DEPTH));
    e_valid = (m_fifo.size() > 0);
    e_inst  = e_valid ? m_fifo[0].data : NOP;
    e_iaddr = e_valid ? m_fifo[0].addr : 32'h0;
    n_vec++;
    if (ibus_req_o !== e_req) begin
      n_err++; $display("FAIL req cyc=%0d got %b expected %b", cyc, ibus_req_o, e_req);
    end
    n_vec++;
    if (ibus_addr_o !== m_pc) begin
      n_err++; $display("FAIL fetch_addr cyc=%0d got %h expected %h", cyc, ibus_addr_o, m_pc);
    end
    n_vec++;
    if (inst_valid_o !== e_valid) begin
      n_err++; $display("FAIL inst_valid cyc=%0d got %b expected %b", cyc, inst_valid_o, e_valid);
    end
    n_vec++;
    if (inst_o !== e_inst) begin
      n_err++; $display("FAIL inst cyc=%0d got %h expected %h", cyc, inst_o, e_inst);
    end
    n_vec++;
    if (inst_addr_o !== e_iaddr) begin
      n_err++; $display("FAIL inst_addr cyc=%0d got %h expected %h", cyc, inst_addr_o, e_iaddr);
    end
    s_req  = ibus_req_o;
    s_addr = ibus_addr_o;
    @(posedge clk);
    resp = ibus_rvalid_i && (m_out.size() > 0);
    if (m_fifo.size() > 0 && inst_ready_i && !jump_flag_i) void'(m_fifo.pop_front());
    if (resp) begin
      r = m_out.pop_front();
      if (!r.stale && !jump_flag_i) m_fifo.push_back('{r.addr, mem(r.addr)});
    end
    if (e_req && ibus_gnt_i) begin
      m_out.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (jump_flag_i) begin
      m_fifo.delete();
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      m_pc = {jump_addr_i[31:2], 2'b00};
    end
    if (from_bus) void'(bus_q.pop_front());
    if (s_req && ibus_gnt_i) begin
      due = cyc + $urandom_range(lat_lo, lat_hi);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      bus_q.push_back('{s_addr, due});
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    bus_hold_flag_i = 1'b1; inst_ready_i = 1'b1;
    repeat (8) step();
    bus_hold_flag_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0; bus_hold_flag_i = 1'b0;
    ibus_gnt_i = 1'b1; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0; inst_ready_i = 1'b1;
    m_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ibus_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got %b expected 0", ibus_req_o); end
    n_vec++; if (ibus_addr_o !== RESET_PC) begin n_err++; $display("FAIL reset_addr got %h expected %h", ibus_addr_o, RESET_PC); end
    n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b expected 0", inst_valid_o); end
    n_vec++; if (inst_o !== NOP) begin n_err++; $display("FAIL reset_inst got %h expected %h", inst_o, NOP); end
    n_vec++; if (inst_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_inst_addr got %h expected 0", inst_addr_o); end
  endtask

  task automatic test_stream();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1; inst_ready_i = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k >= 1) begin
        n_vec++;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(4 * (k - 1)) || inst_o !== mem(32'(4 * (k - 1)))) begin
          n_err++;
          $display("FAIL stream k=%0d got v=%b a=%h d=%h expected v=1 a=%h d=%h", k, inst_valid_o,
                   inst_addr_o, inst_o, 32'(4 * (k - 1)), mem(32'(4 * (k - 1))));
        end
      end
    end
  endtask

  task automatic test_full();
    int grants;
    drain();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1; inst_ready_i = 1'b0; grants = 0;
    repeat (8) begin
      step();
      if (s_req && ibus_gnt_i) grants++;
    end
    n_vec++;
    if (grants != int'(DEPTH)) begin n_err++; $display("FAIL full_grants got %0d expected %0d", grants, DEPTH); end
    n_vec++;
    if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b1) begin
      n_err++; $display("FAIL full_state got req=%b valid=%b expected req=0 valid=1", ibus_req_o, inst_valid_o);
    end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    n_vec++;
    if (ibus_req_o !== 1'b1) begin n_err++; $display("FAIL full_reissue got req=%b expected 1", ibus_req_o); end
    repeat (3) step();
  endtask

  task automatic test_jump();
    bit seen;
    drain();
    gnt_pct = 100; lat_lo = 3; lat_hi = 3; inst_ready_i = 1'b0;
    jump_flag_i = 1'b1; jump_addr_i = 32'h10; step(); jump_flag_i = 1'b0;
    step(); step();
    jump_flag_i = 1'b1; jump_addr_i = 32'h100; step(); jump_flag_i = 1'b0;
    lat_lo = 1; lat_hi = 1; inst_ready_i = 1'b1; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = inst_valid_o;
    end
    n_vec++;
    if (!seen || inst_addr_o !== 32'h100 || inst_o !== mem(32'h100)) begin
      n_err++; $display("FAIL jump_first seen=%b got a=%h d=%h expected a=00000100 d=%h", seen, inst_addr_o, inst_o, mem(32'h100));
    end
    bus_hold_flag_i = 1'b1;
    jump_flag_i = 1'b1; jump_addr_i = 32'h103; step(); jump_flag_i = 1'b0;
    n_vec++;
    if (ibus_addr_o !== 32'h100) begin n_err++; $display("FAIL jump_align got %h expected 00000100", ibus_addr_o); end
    bus_hold_flag_i = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_hold();
    gnt_pct = 70; lat_lo = 1; lat_hi = 3; inst_ready_i = 1'b1;
    repeat (10) step();
    bus_hold_flag_i = 1'b1;
    repeat (5) begin
      step();
      n_vec++;
      if (s_req !== 1'b0) begin n_err++; $display("FAIL hold_req got %b expected 0", s_req); end
    end
    bus_hold_flag_i = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_collide();
    bit due_now;
    gnt_pct = 70; lat_lo = 1; lat_hi = 2;
    for (int k = 0; k < 300; k++) begin
      due_now = (bus_q.size() > 0) && (bus_q[0].due <= cyc);
      jump_flag_i     = due_now ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      jump_addr_i     = $urandom;
      bus_hold_flag_i = ($urandom_range(0, 9) == 0);
      inst_ready_i    = ($urandom_range(0, 9) < 7);
      step();
    end
    jump_flag_i = 1'b0; bus_hold_flag_i = 1'b0; inst_ready_i = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_stray();
    drain();
    bus_hold_flag_i = 1'b1; stray_en = 1'b1;
    repeat (6) begin
      step();
      n_vec++;
      if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL stray_valid got %b expected 0", inst_valid_o); end
    end
    stray_en = 1'b0; bus_hold_flag_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    drain();
    gnt_pct = 100; lat_lo = 3; lat_hi = 3; inst_ready_i = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (ibus_req_o !== 1'b0) begin n_err++; $display("FAIL midrst_req got %b expected 0", ibus_req_o); end
    n_vec++; if (ibus_addr_o !== RESET_PC) begin n_err++; $display("FAIL midrst_addr got %h expected %h", ibus_addr_o, RESET_PC); end
    n_vec++; if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
      n_err++; $display("FAIL midrst_inst got v=%b d=%h a=%h expected v=0 d=%h a=0", inst_valid_o, inst_o, inst_addr_o, NOP);
    end
    m_fifo.delete(); m_out.delete(); bus_q.delete(); m_pc = RESET_PC;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; inst_ready_i = 1'b1; lat_lo = 1; lat_hi = 2;
    step();
    n_vec++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      n_err++; $display("FAIL midrst_restart got req=%b addr=%h expected req=1 addr=%h", s_req, s_addr, RESET_PC);
    end
    repeat (12) step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_jump();
    test_hold();
    test_collide();
    test_stray();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
